// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter for the GPR file's single write port plus a pending-write scoreboard.
// Define GPR_WB_ARB_RR_EN for round-robin grant order; otherwise the lowest index wins.
module gpr_wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int W_DATA = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][4:0]        req_regf,
    input  logic [N_REQ-1:0][W_DATA-1:0] req_data,
    output logic [4:0]                   wr_regf,
    output logic [W_DATA-1:0]            wr_data,
    input  logic                         sb_set_valid,
    input  logic [4:0]                   sb_set_regf,
    input  logic [4:0]                   rs_regf,
    input  logic [4:0]                   rt_regf,
    output logic                         rs_busy,
    output logic                         rt_busy
);
    localparam int LW = $clog2(N_REQ);

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] discard;
    logic             grant_vld;
    logic [LW-1:0]    grant_idx;
    logic [4:0]       grant_regf;
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;

    // Handshake: a requester holds valid/regf/data stable until the cycle where
    // valid & ready are both high; that cycle is the transfer. Index-0 requests
    // are discards and are accepted immediately without touching the write port.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            discard[i]  = req_valid[i] && (req_regf[i] == 5'd0);
            eligible[i] = req_valid[i] && (req_regf[i] != 5'd0);
        end
    end

`ifdef GPR_WB_ARB_RR_EN
    logic [LW-1:0] last_q;

    always_comb begin
        logic [LW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last_q) + k) % N_REQ);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= LW'(N_REQ - 1);
        end else if (grant_vld) begin
            last_q <= grant_idx;
        end
    end
`else
    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_vld = 1'b1;
                grant_idx = LW'(i);
            end
        end
    end
`endif

    assign grant_regf = req_regf[grant_idx];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = !rst && (discard[i] || (grant_vld && (grant_idx == LW'(i))));
        end
    end

    // A set in the same cycle as the clear belongs to a newer producer, so it wins.
    always_comb begin
        busy_d = busy_q;
        if (grant_vld) begin
            busy_d[grant_regf] = 1'b0;
        end
        if (sb_set_valid) begin
            busy_d[sb_set_regf] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_regf <= 5'd0;
            wr_data <= '0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (grant_vld) begin
                wr_regf <= grant_regf;
                wr_data <= req_data[grant_idx];
            end else begin
                wr_regf <= 5'd0;
            end
        end
    end

    assign rs_busy = busy_q[rs_regf];
    assign rt_busy = busy_q[rt_regf];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed plan checks plus randomized traffic against a
// behavioural model (grant choice, one-deep write-port queue, busy bit array).
module tb_gpr_wb_arbiter;
    localparam int N = 3;
    localparam int W = 32;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][4:0]  req_regf;
    logic [N-1:0][W-1:0] req_data;
    logic [4:0]         wr_regf;
    logic [W-1:0]       wr_data;
    logic               sb_set_valid;
    logic [4:0]         sb_set_regf;
    logic [4:0]         rs_regf;
    logic [4:0]         rt_regf;
    logic               rs_busy;
    logic               rt_busy;

    gpr_wb_arbiter #(.N_REQ(N), .W_DATA(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_regf(req_regf), .req_data(req_data),
        .wr_regf(wr_regf), .wr_data(wr_data),
        .sb_set_valid(sb_set_valid), .sb_set_regf(sb_set_regf),
        .rs_regf(rs_regf), .rt_regf(rt_regf),
        .rs_busy(rs_busy), .rt_busy(rt_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [W-1:0] d);
        req_valid[i] = v;
        req_regf[i]  = r;
        req_data[i]  = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'd0, '0);
    endtask

    // behavioural model
    logic          cmp_en = 1'b0;
    int            m_last = N - 1;
    logic [31:0]   m_busy = '0;
    logic [W-1:0]  hold_data = '0;
    logic [N-1:0]  mdl_ready = '0;
    logic [W+4:0]  exp_q[$];

    function automatic int pick(input logic [N-1:0] elig, input int last);
`ifdef GPR_WB_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (elig[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (elig[i]) return i;
        end
`endif
        return -1;
    endfunction

    // scoreboard / compare process
    always @(negedge clk) begin
        if (cmp_en) begin
            int g;
            logic [N-1:0] elig;
            logic [N-1:0] er;
            logic [W+4:0] exp_wr;
            for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (req_regf[i] != 5'd0);
            g = pick(elig, m_last);
            for (int i = 0; i < N; i++)
                er[i] = !rst && req_valid[i] && ((req_regf[i] == 5'd0) || (i == g));
            chk("req_ready", req_ready, er);
            chk("rs_busy", rs_busy, m_busy[rs_regf]);
            chk("rt_busy", rt_busy, m_busy[rt_regf]);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL exp_q: expected-queue empty at %0t", $time);
            end else begin
                exp_wr = exp_q.pop_front();
                chk("wr_regf", wr_regf, exp_wr[W+4:W]);
                chk("wr_data", wr_data, exp_wr[W-1:0]);
            end
            mdl_ready = er;
            if (rst) begin
                m_last    = N - 1;
                m_busy    = '0;
                hold_data = '0;
                exp_q.delete();
                exp_q.push_back('0);
            end else begin
                if (g >= 0) begin
                    m_busy[req_regf[g]] = 1'b0;
                    hold_data = req_data[g];
                    exp_q.push_back({req_regf[g], req_data[g]});
                    m_last = g;
                end else begin
                    exp_q.push_back({5'd0, hold_data});
                end
                if (sb_set_valid && sb_set_regf != 5'd0) m_busy[sb_set_regf] = 1'b1;
            end
        end
    end

    logic [N-1:0] cont_rdy[4];
    logic [4:0]   cont_wr[4];

    initial begin
`ifdef GPR_WB_ARB_RR_EN
        cont_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
        cont_wr  = '{5'd1, 5'd2, 5'd3, 5'd1};
`else
        cont_rdy = '{3'b001, 3'b001, 3'b001, 3'b001};
        cont_wr  = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
        exp_q.push_back('0);
        rst = 1'b1;
        sb_set_valid = 1'b0;
        sb_set_regf = 5'd0;
        rs_regf = 5'd0;
        rt_regf = 5'd0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), W'(32'h100 + i));

        // reset: two cycles with everyone valid
        tick();
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_wr_regf", wr_regf, 5'd0);
        for (int r = 0; r < 32; r++) begin
            rs_regf = 5'(r);
            rt_regf = 5'(31 - r);
            #1;
            chk("rst_rs_busy", rs_busy, 1'b0);
            chk("rst_rt_busy", rt_busy, 1'b0);
        end
        rs_regf = 5'd0;
        rt_regf = 5'd0;
        tick();
        rst = 1'b0;

        // single write
        clear_reqs();
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("single_ready", req_ready, 3'b010);
        tick();
        clear_reqs();
        @(negedge clk);
        #1;
        chk("single_wr_regf", wr_regf, 5'd5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        #1;
        chk("single_idle", wr_regf, 5'd0);

        // contention from a fresh reset
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), W'(32'h200 + i));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("cont_ready", req_ready, cont_rdy[c]);
            if (c > 0) chk("cont_wr", wr_regf, cont_wr[c - 1]);
            tick();
        end
        @(negedge clk);
        #1;
        chk("cont_wr", wr_regf, cont_wr[3]);
        tick();
        clear_reqs();

        // discard alongside a real write
        set_req(0, 1'b1, 5'd0, 32'h1111);
        set_req(2, 1'b1, 5'd7, 32'h7777);
        @(negedge clk);
        #1;
        chk("disc_ready", req_ready, 3'b101);
        tick();
        clear_reqs();
        @(negedge clk);
        #1;
        chk("disc_wr_regf", wr_regf, 5'd7);

        // scoreboard set / same-cycle set-vs-clear / final clear
        tick();
        sb_set_valid = 1'b1;
        sb_set_regf  = 5'd9;
        rs_regf      = 5'd9;
        rt_regf      = 5'd9;
        @(negedge clk);
        #1;
        chk("sb_before", rs_busy, 1'b0);
        tick();
        sb_set_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("sb_set_rs", rs_busy, 1'b1);
        chk("sb_set_rt", rt_busy, 1'b1);
        tick();
        set_req(1, 1'b1, 5'd9, 32'h99);
        sb_set_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("sb_grant_ready", req_ready, 3'b010);
        tick();
        clear_reqs();
        sb_set_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("sb_set_wins", rs_busy, 1'b1);
        chk("sb_wr_regf", wr_regf, 5'd9);
        tick();
        set_req(1, 1'b1, 5'd9, 32'h9A);
        @(negedge clk);
        #1;
        chk("sb_still_busy", rs_busy, 1'b1);
        tick();
        clear_reqs();
        @(negedge clk);
        #1;
        chk("sb_cleared", rs_busy, 1'b0);
        chk("sb_wr_data", wr_data, 32'h9A);
        tick();

        // randomized traffic; requesters keep a request until the model saw it accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (mdl_ready[i] || !req_valid[i]) begin
                    set_req(i, $urandom_range(0, 99) < 60,
                            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                            $urandom);
                end
            end
            rst          = ($urandom_range(0, 199) == 0);
            sb_set_valid = ($urandom_range(0, 2) == 0);
            sb_set_regf  = 5'($urandom_range(0, 7));
            rs_regf      = 5'($urandom_range(0, 7));
            rt_regf      = 5'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        clear_reqs();
        sb_set_valid = 1'b0;
        tick();
        tick();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
